// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, DATA_WIDTH data bits LSB first,
// optional parity, one stop bit). Each bit is resolved by a 3-sample majority
// vote around mid-bit.
// Optional feature: define UART_RX_SYNC_EN to place a 2-flop synchronizer
// (reset to 1) in front of RX_IN; all timing is then referenced to the
// synchronized line, two CLK later than the pin.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  parity_EN,
  input  logic                  parity_type,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  r_state;
  logic [PRESCALE_W-1:0]   r_edge_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [PRESCALE_W-1:0]   r_presc;
  logic                    r_par_en;
  logic                    r_par_type;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_smp_a;
  logic                    r_smp_b;

  logic                    w_rx;
  logic [PRESCALE_W-1:0]   w_presc_legal;
  logic [PRESCALE_W-1:0]   w_half;
  logic [PRESCALE_W-1:0]   w_last;
  logic                    w_at_a;
  logic                    w_at_b;
  logic                    w_at_c;
  logic                    w_wrap;
  logic                    w_bit;
  logic                    w_par_exp;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer on the raw serial pin; idles high out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX_IN};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = RX_IN;
`endif

  // Unsupported oversampling ratios fall back to 8.
  assign w_presc_legal = ((Prescale == PRESCALE_W'(8))  ||
                          (Prescale == PRESCALE_W'(16)) ||
                          (Prescale == PRESCALE_W'(32))) ? Prescale : PRESCALE_W'(8);

  assign w_half    = r_presc >> 1;
  assign w_last    = r_presc - PRESCALE_W'(1);
  assign w_at_a    = (r_edge_cnt == (w_half - PRESCALE_W'(1)));
  assign w_at_b    = (r_edge_cnt == w_half);
  assign w_at_c    = (r_edge_cnt == (w_half + PRESCALE_W'(1)));
  assign w_wrap    = (r_edge_cnt == w_last);
  assign w_bit     = (r_smp_a & r_smp_b) | (r_smp_a & w_rx) | (r_smp_b & w_rx);
  assign w_par_exp = r_par_type ? ~(^r_shift) : (^r_shift);

  // Frame FSM with edge/bit counters, sampling, error flags and data output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_presc      <= PRESCALE_W'(8);
      r_par_en     <= 1'b0;
      r_par_type   <= 1'b0;
      r_shift      <= '0;
      r_smp_a      <= 1'b0;
      r_smp_b      <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (r_state != S_IDLE) begin
        if (w_at_a) r_smp_a <= w_rx;
        if (w_at_b) r_smp_b <= w_rx;
        r_edge_cnt <= w_wrap ? '0 : (r_edge_cnt + PRESCALE_W'(1));
      end

      case (r_state)
        S_IDLE: begin
          // The cycle that first sees the line low is edge 0 of the start bit.
          if (!w_rx) begin
            r_state    <= S_START;
            r_edge_cnt <= PRESCALE_W'(1);
            r_bit_cnt  <= '0;
            r_presc    <= w_presc_legal;
            r_par_en   <= parity_EN;
            r_par_type <= parity_type;
          end
        end

        S_START: begin
          if (w_at_c && w_bit) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else begin
            if (w_at_c) begin
              parity_error <= 1'b0;
              stop_error   <= 1'b0;
            end
            if (w_wrap) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
        end

        S_DATA: begin
          if (w_at_c) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_wrap) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (w_at_c && (w_bit != w_par_exp)) parity_error <= 1'b1;
          if (w_wrap) r_state <= S_STOP;
        end

        S_STOP: begin
          if (w_at_c && !w_bit) stop_error <= 1'b1;
          if (w_wrap) begin
            // Returning through IDLE lets a back-to-back start bit be caught
            // in the very next cycle.
            r_state <= S_IDLE;
            if (!parity_error && !stop_error) begin
              P_DATA     <= r_shift;
              data_valid <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (default build, no synchronizer).
// A frame-level model predicts, per cycle, data_valid, P_DATA and the error
// flags from the bit times of each transmitted frame.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          parity_EN = 1'b0;
  logic          parity_type = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .parity_EN    (parity_EN),
    .parity_type  (parity_type),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;

  // Model state: expected outputs for the current cycle.
  int          cyc = 0;
  int          dv_due = -1;
  logic [7:0]  dv_byte = 8'h00;
  logic        exp_dv = 1'b0;
  logic [7:0]  exp_data = 8'h00;
  logic        exp_pe = 1'b0;
  logic        exp_se = 1'b0;
  bit          chk_en = 1'b0;

  int          tests = 0;
  int          fails = 0;
  int          dv_count = 0;
  int          last_dv_cyc = -1;
  int          prev_dv_cyc = -1;
  logic [7:0]  last_dv_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("data_valid", 32'(data_valid), 32'(exp_dv));
      check("P_DATA", 32'(P_DATA), 32'(exp_data));
      check("parity_error", 32'(parity_error), 32'(exp_pe));
      check("stop_error", 32'(stop_error), 32'(exp_se));
      if (data_valid === 1'b1) begin
        dv_count++;
        prev_dv_cyc  = last_dv_cyc;
        last_dv_cyc  = cyc;
        last_dv_data = P_DATA;
      end
    end
  end

  // Advance one cycle; inputs are then driven for that cycle by the caller.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    exp_dv = (cyc == dv_due);
    if (exp_dv) exp_data = dv_byte;
  endtask

  task automatic rand_cfg();
    Prescale    = PW'($urandom);
    parity_EN   = 1'($urandom);
    parity_type = 1'($urandom);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      RX_IN = 1'b1;
      rand_cfg();
    end
  endtask

  // Send one frame; configuration is only valid in its first cycle, random after.
  // Returns early (no data_valid expected) when abort_at is reached.
  task automatic send_frame(input logic [7:0] data, input logic [PW-1:0] psc,
                            input logic pen, input logic ptype,
                            input logic bad_par, input logic bad_stop,
                            input bit noisy, input int abort_at, output int s);
    int p, n, gpos;
    logic [10:0] bits;
    logic b;
    p = ((psc == PW'(8)) || (psc == PW'(16)) || (psc == PW'(32))) ? int'(psc) : 8;
    n = pen ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (pen) bits[9] = (^data) ^ ptype ^ bad_par;
    bits[n-1] = ~bad_stop;
    gpos = 3;
    s = 0;
    for (int c = 0; c < n * p; c++) begin
      if (c == abort_at) return;
      tick();
      if (c == 0) s = cyc;
      if ((c % p) == 0) gpos = noisy ? int'($urandom_range(0, 3)) : 3;
      b = bits[c / p];
      // One of the three vote samples may be corrupted; majority must still win.
      if (gpos < 3 && (c % p) == (p / 2 - 1 + gpos)) b = ~b;
      RX_IN = b;
      if (c == 0) begin
        Prescale    = psc;
        parity_EN   = pen;
        parity_type = ptype;
      end else begin
        rand_cfg();
      end
      // Flag updates become visible the cycle after the mid-bit decision.
      if (c == p / 2 + 2) begin
        exp_pe = 1'b0;
        exp_se = 1'b0;
      end
      if (pen && bad_par && c == 9 * p + p / 2 + 2) exp_pe = 1'b1;
      if (bad_stop && c == (n - 1) * p + p / 2 + 2) exp_se = 1'b1;
    end
    if (!((pen && bad_par) || bad_stop)) begin
      dv_due  = s + n * p;
      dv_byte = data;
    end
  endtask

  // Runaway guard.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s, s1, dvc;
    logic [PW-1:0] psc;
    int sel, gap;

    // Reset state.
    #1 RST = 1'b0;
    chk_en = 1'b1;
    idle(3);
    check("rst P_DATA", 32'(P_DATA), 32'h0);
    check("rst data_valid", 32'(data_valid), 32'h0);
    check("rst parity_error", 32'(parity_error), 32'h0);
    check("rst stop_error", 32'(stop_error), 32'h0);
    tick();
    RST = 1'b1;
    idle(4);

    // 0xA5, P=8, even parity: pulse 88 cycles after start.
    send_frame(8'hA5, PW'(8), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    idle(3);
    check("A5 latency", 32'(last_dv_cyc - s), 32'd88);
    check("A5 data", 32'(last_dv_data), 32'hA5);
    check("A5 dv count", 32'(dv_count), 32'd1);

    // 0x3C, P=16, odd parity with the wrong parity bit (0): parity error, P_DATA kept.
    dvc = dv_count;
    send_frame(8'h3C, PW'(16), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, s);
    idle(3);
    check("3C parity_error", 32'(parity_error), 32'h1);
    check("3C stop_error", 32'(stop_error), 32'h0);
    check("3C no pulse", 32'(dv_count), 32'(dvc));
    check("3C P_DATA kept", 32'(P_DATA), 32'hA5);

    // 0xFF, P=32, no parity, stop bit 0: stop error.
    send_frame(8'hFF, PW'(32), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, s);
    idle(3);
    check("FF stop_error", 32'(stop_error), 32'h1);
    check("FF parity_error", 32'(parity_error), 32'h0);
    check("FF no pulse", 32'(dv_count), 32'(dvc));

    // Two-cycle low glitch from idle: no pulse, flags untouched.
    tick(); RX_IN = 1'b0; Prescale = PW'(8); parity_EN = 1'b0; parity_type = 1'b0;
    tick(); RX_IN = 1'b0;
    idle(20);
    check("glitch stop_error kept", 32'(stop_error), 32'h1);
    check("glitch no pulse", 32'(dv_count), 32'(dvc));

    // Good 0x12 clears the flags.
    send_frame(8'h12, PW'(32), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    idle(3);
    check("12 data", 32'(last_dv_data), 32'h12);
    check("12 stop_error", 32'(stop_error), 32'h0);
    check("12 dv count", 32'(dv_count), 32'(dvc + 1));

    // Back-to-back 0x01, 0x80 at P=8 without parity: pulses 80 cycles apart.
    dvc = dv_count;
    send_frame(8'h01, PW'(8), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    send_frame(8'h80, PW'(8), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, s1);
    idle(3);
    check("b2b spacing", 32'(last_dv_cyc - prev_dv_cyc), 32'd80);
    check("b2b start spacing", 32'(s1 - s), 32'd80);
    check("b2b data", 32'(last_dv_data), 32'h80);
    check("b2b dv count", 32'(dv_count), 32'(dvc + 2));

    // Reset in the middle of data bit 4 of 0x55.
    dvc = dv_count;
    send_frame(8'h55, PW'(8), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5 * 8 + 3, s);
    tick();
    RST = 1'b0;
    RX_IN = 1'b1;
    exp_dv = 1'b0; exp_data = 8'h00; exp_pe = 1'b0; exp_se = 1'b0;
    dv_due = -1;
    idle(3);
    check("midrst P_DATA", 32'(P_DATA), 32'h0);
    check("midrst data_valid", 32'(data_valid), 32'h0);
    tick();
    RST = 1'b1;
    idle(12);
    check("midrst no pulse", 32'(dv_count), 32'(dvc));
    send_frame(8'hAA, PW'(8), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    idle(3);
    check("AA data", 32'(last_dv_data), 32'hAA);
    check("AA dv count", 32'(dv_count), 32'(dvc + 1));

    // Randomized frames: ratio, parity mode, errors, vote noise, gaps.
    for (int f = 0; f < 40; f++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0, 1: psc = PW'(8);
        2:    psc = PW'(16);
        3:    psc = PW'(32);
        default: begin
          psc = PW'($urandom);
          while (psc == PW'(8) || psc == PW'(16) || psc == PW'(32)) psc = PW'($urandom);
        end
      endcase
      send_frame(8'($urandom), psc, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), -1, s);
      gap = int'($urandom_range(0, 12));
      idle(gap);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
